led_blinker: RTL
================

LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 250000, giving clk cycles per blink tick (minimum 2).
REQ-002 The block SHALL have parameter ON_TICKS, default 40, giving ticks the LED is lit per blink (minimum 1).
REQ-003 The block SHALL have parameter OFF_TICKS, default 40, giving dark ticks after each blink (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is in this domain.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, 1 bit, a one-cycle request to start a blink sequence.
REQ-007 The block SHALL have port count, input, 4 bits, the number of blinks, sampled with req.
REQ-008 The block SHALL have port stop, input, 1 bit, which aborts the current sequence.
REQ-009 The block SHALL have port led, output, 1 bit, the registered LED drive, active-high.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the block is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse on normal sequence completion.

Function
REQ-012 The tick prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick is high when the count equals CLK_DIV-1.
REQ-013 The FSM SHALL have states IDLE, ON and OFF, and all outputs SHALL be registered.
REQ-014 In IDLE, req=1 with count!=0 SHALL latch count into remaining, clear the prescaler and the tick counter, and move to ON; led rises in the next cycle.
REQ-015 req with count=0 SHALL be ignored: no state change and no done.
REQ-016 req while busy SHALL be ignored; there is no queueing.
REQ-017 In ON, the block SHALL count ticks; on the ON_TICKS-th tick it SHALL clear led, decrement remaining and move to OFF, so led is high for exactly ON_TICKS*CLK_DIV cycles.
REQ-018 In OFF, on the OFF_TICKS-th tick:
  - if remaining!=0, the block SHALL set led and move to ON;
  - otherwise it SHALL move to IDLE, with done=1 for exactly the first IDLE cycle.
REQ-019 busy SHALL fall in the same cycle done rises.
REQ-020 A req in the cycle where done=1 SHALL be accepted.
REQ-021 stop=1 in ON or OFF SHALL, in the next cycle, give led=0, busy=0 and state IDLE, with no done pulse.
REQ-022 stop=1 in IDLE SHALL have no effect.
REQ-023 When stop and req are both high in IDLE, stop SHALL win and req SHALL be dropped.
REQ-024 The tick counter width SHALL be $clog2 of max(ON_TICKS, OFF_TICKS)+1, and the prescaler width SHALL be $clog2(CLK_DIV).
REQ-025 All counters SHALL compare with >= so an illegal value self-recovers and cannot lock up.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=IDLE, led=0, busy=0, done=0, and remaining, tick counter and prescaler all to 0.
REQ-027 Reset asserted mid-sequence SHALL abort it with no done pulse.
REQ-028 Reset deassertion SHALL be synchronized externally; the first active edge after deassertion SHALL be a normal IDLE cycle.

Structure
REQ-029 The FSM state encoding (IDLE/ON/OFF) and the default timing constants SHALL reside in a shared package, led_pkg, reused by future indicator blocks.
REQ-030 The prescaler SHALL be one sub-module, tick_gen, with ports clk, rst_n, clr and tick and parameter CLK_DIV.
REQ-031 led_blinker SHALL instantiate exactly one tick_gen and contain no other sub-modules.

Verification
All scenarios use CLK_DIV=4, ON_TICKS=2, OFF_TICKS=3, with req pulsed in cycle 0.
REQ-032 Single blink: req with count=1 -> led=1 in cycles 1..8, led=0 in cycles 9..20, done=1 and busy=0 in cycle 21 only.
REQ-033 Triple blink: req with count=3 -> three 8-cycle led pulses starting at cycles 1, 21 and 41; done in cycle 61 only.
REQ-034 Ignored requests:
  - req with count=0 -> busy stays 0 and no done;
  - a second req at cycle 5 during a count=1 sequence -> timing identical to the single-blink scenario.
REQ-035 Abort: stop=1 at cycle 12 during a count=2 sequence -> led=0 and busy=0 from cycle 13 and no done; stop together with req in IDLE -> nothing starts.
REQ-036 Back-to-back and reset:
  - req with count=1 driven in the done cycle (cycle 21) -> led=1 in cycle 22;
  - rst_n low at cycle 5 -> led, busy and done are 0 immediately, and a req after release starts cleanly.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for LED indicator blocks.
//   led_state_e   : FSM encoding (IDLE / ON / OFF)
//   DEF_*         : default blink timing constants
//   max_int()     : elaboration-time helper for sizing counters
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } led_state_e;

    localparam int DEF_CLK_DIV   = 250000;
    localparam int DEF_ON_TICKS  = 40;
    localparam int DEF_OFF_TICKS = 40;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Blink tick prescaler: counts 0..CLK_DIV-1 and wraps.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count at 0 on the next edge
//   tick       : high while the count is at its terminal value
module tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int                PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int                TOP_I = CLK_DIV - 1;
    localparam int                ONE_I = 1;
    localparam logic [PRE_W-1:0]  TOP   = TOP_I[PRE_W-1:0];
    localparam logic [PRE_W-1:0]  ONE   = ONE_I[PRE_W-1:0];

    logic [PRE_W-1:0] cnt_q, cnt_d;

    // >= so an out-of-range count wraps immediately instead of running on
    assign tick = (cnt_q >= TOP);

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_blinker.sv
// Blinks an LED a requested number of times.
//   clk, rst_n : clock, async active-low reset
//   req, count : one-cycle start request with blink count (0 ignored)
//   stop       : abort the running sequence (no done)
//   led        : registered LED drive, active-high
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse on normal completion
module led_blinker
    import led_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] count,
    input  logic       stop,
    output logic       led,
    output logic       busy,
    output logic       done
);
    localparam int              TICK_W = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);
    localparam int              ONE_I  = 1;
    localparam logic [TICK_W:0] ON_LIM  = ON_TICKS[TICK_W:0];
    localparam logic [TICK_W:0] OFF_LIM = OFF_TICKS[TICK_W:0];
    localparam logic [TICK_W:0] T_ONE   = ONE_I[TICK_W:0];

    led_state_e        state_q, state_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        remaining_q, remaining_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_W:0]   tick_nxt;
    logic              tick;
    logic              clr;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        tick_cnt_d  = tick_cnt_q;
        clr         = 1'b0;
        // one bit wider so the >= compare cannot overflow
        tick_nxt    = {1'b0, tick_cnt_q} + T_ONE;

        case (state_q)
            ST_IDLE: begin
                led_d = 1'b0;
                // stop has priority over a simultaneous req
                if (req && !stop && (count != 4'd0)) begin
                    state_d     = ST_ON;
                    led_d       = 1'b1;
                    remaining_d = count;
                    tick_cnt_d  = '0;
                    clr         = 1'b1;
                end
            end

            ST_ON: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    led_d      = 1'b0;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (tick_nxt >= ON_LIM) begin
                        state_d     = ST_OFF;
                        led_d       = 1'b0;
                        tick_cnt_d  = '0;
                        // saturate so a corrupted zero still ends the sequence
                        remaining_d = (remaining_q != 4'd0) ? remaining_q - 4'd1 : 4'd0;
                    end else begin
                        tick_cnt_d = tick_nxt[TICK_W-1:0];
                    end
                end
            end

            ST_OFF: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    led_d      = 1'b0;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (tick_nxt >= OFF_LIM) begin
                        tick_cnt_d = '0;
                        if (remaining_q != 4'd0) begin
                            state_d = ST_ON;
                            led_d   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_nxt[TICK_W-1:0];
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                led_d      = 1'b0;
                tick_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= 4'd0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
